midi_voice_allocator: RTL

- Parametrised successor of the fixed MIDI decoder: parses the UART MIDI byte stream and keeps a NUM_CH x VOICES polyphonic note table for the DDS and LCD.
- Adds running status, realtime filtering, retrigger, voice stealing and All-Notes-Off.
- Sits between UART_Rx and NoteNumTable/DDS/LCD_Controller in the 9 MHz domain.
- Read-port word format is unchanged, so downstream blocks need no edits.

---
 rtl/midi_pkg.sv | 40 ++++
 rtl/midi_parser.sv | 132 +++++++++++++
 rtl/midi_voice_allocator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON = 4'h9;
  localparam logic [3:0] ST_CC = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_ON,
    CMD_OFF,
    CMD_ALLOFF
  } cmd_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DATA1,
    P_DATA2
  } pst_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_SCAN,
    E_COMMIT
  } est_e;

  typedef struct packed {
    logic       active;
    logic [6:0] note;
    logic [6:0] vel;
    logic [2:0] age;
  } slot_t;

  function automatic logic [15:0] rd_word(slot_t s);
    return {s.active, s.note, 1'b0, s.vel};
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI byte stream parser: running status, realtime filtering,
// emits a one-cycle {cmd, ch, key, val} strobe.
module midi_parser
  import midi_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_rx_flg,
  input  logic [7:0] i_rx_data,
  output logic       o_vld,
  output cmd_e       o_cmd,
  output logic [3:0] o_ch,
  output logic [6:0] o_key,
  output logic [6:0] o_val,
  output logic       o_drop
);

  pst_e       st_q, st_d;
  logic       rs_vld_q, rs_vld_d;
  logic [3:0] rs_st_q, rs_st_d;
  logic [3:0] rs_ch_q, rs_ch_d;
  logic [6:0] key_q, key_d;
  logic [6:0] val_q, val_d;
  logic [3:0] ch_q, ch_d;
  cmd_e       cmd_q, cmd_d;
  logic       vld_q, vld_d;
  logic       drop_q, drop_d;
  logic       voice_st;

  assign voice_st = (i_rx_data[7:4] == ST_NOTE_ON)
                 || (i_rx_data[7:4] == ST_NOTE_OFF)
                 || (i_rx_data[7:4] == ST_CC);

  always_comb begin
    st_d = st_q;
    rs_vld_d = rs_vld_q;
    rs_st_d = rs_st_q;
    rs_ch_d = rs_ch_q;
    key_d = key_q;
    val_d = val_q;
    ch_d = ch_q;
    cmd_d = cmd_q;
    vld_d = 1'b0;
    drop_d = 1'b0;
    if (i_rx_flg) begin
      if (i_rx_data[7]) begin
        // Realtime bytes (F8-FF) pass through without touching state.
        if (i_rx_data[7:3] != 5'b11111) begin
          if (voice_st && int'(i_rx_data[3:0]) < NUM_CH) begin
            rs_vld_d = 1'b1;
            rs_st_d = i_rx_data[7:4];
            rs_ch_d = i_rx_data[3:0];
            st_d = P_DATA1;
          end else begin
            rs_vld_d = 1'b0;
            st_d = P_IDLE;
          end
        end
      end else begin
        unique case (st_q)
          P_IDLE: begin
            if (rs_vld_q) begin
              key_d = i_rx_data[6:0];
              st_d = P_DATA2;
            end else begin
              drop_d = 1'b1;
            end
          end
          P_DATA1: begin
            key_d = i_rx_data[6:0];
            st_d = P_DATA2;
          end
          P_DATA2: begin
            val_d = i_rx_data[6:0];
            ch_d = rs_ch_q;
            st_d = P_DATA1;
            cmd_d = CMD_NONE;
            case (rs_st_q)
              ST_NOTE_ON:
                cmd_d = (i_rx_data[6:0] != 7'd0) ? CMD_ON : CMD_OFF;
              ST_NOTE_OFF:
                cmd_d = CMD_OFF;
              ST_CC:
                if (key_q == CC_ALL_NOTES_OFF
                    || key_q == CC_ALL_SOUND_OFF)
                  cmd_d = CMD_ALLOFF;
              default: cmd_d = CMD_NONE;
            endcase
            vld_d = (cmd_d != CMD_NONE);
          end
          default: st_d = P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      st_q <= P_IDLE;
      rs_vld_q <= 1'b0;
      rs_st_q <= '0;
      rs_ch_q <= '0;
      key_q <= '0;
      val_q <= '0;
      ch_q <= '0;
      cmd_q <= CMD_NONE;
      vld_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rs_vld_q <= rs_vld_d;
      rs_st_q <= rs_st_d;
      rs_ch_q <= rs_ch_d;
      key_q <= key_d;
      val_q <= val_d;
      ch_q <= ch_d;
      cmd_q <= cmd_d;
      vld_q <= vld_d;
      drop_q <= drop_d;
    end
  end

  assign o_vld = vld_q;
  assign o_cmd = cmd_q;
  assign o_ch = ch_q;
  assign o_key = key_q;
  assign o_val = val_q;
  assign o_drop = drop_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI note table: per-channel slot scan, retrigger,
// oldest-voice stealing and All-Notes-Off, with a registered read port.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int VOICES = 4,
  parameter int STEAL_EN = 1,
  parameter int ADDR_W = $clog2(NUM_CH*VOICES)
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_rx_flg,
  input  logic [7:0]        i_rx_data,
  input  logic [ADDR_W-1:0] i_rdaddr,
  output logic [15:0]       o_rddata,
  output logic              o_busy,
  output logic              o_drop
);

  localparam int NSLOT = NUM_CH * VOICES;
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [2:0] AGE_MAX = 3'(VOICES - 1);

  logic       p_vld;
  cmd_e       p_cmd;
  logic [3:0] p_ch;
  logic [6:0] p_key;
  logic [6:0] p_val;
  logic       p_drop;

  midi_parser #(.NUM_CH(NUM_CH)) u_parser (
    .i_clk    (i_clk),
    .i_res    (i_res),
    .i_rx_flg (i_rx_flg),
    .i_rx_data(i_rx_data),
    .o_vld    (p_vld),
    .o_cmd    (p_cmd),
    .o_ch     (p_ch),
    .o_key    (p_key),
    .o_val    (p_val),
    .o_drop   (p_drop)
  );

  est_e          st_q, st_d;
  cmd_e          cmd_q, cmd_d;
  logic [3:0]    ch_q, ch_d;
  logic [6:0]    key_q, key_d;
  logic [6:0]    val_q, val_d;
  logic [VW-1:0] idx_q, idx_d;
  logic          hit_q, hit_d, free_q, free_d, old_q, old_d;
  logic [VW-1:0] hit_i_q, hit_i_d, free_i_q, free_i_d;
  logic [VW-1:0] old_i_q, old_i_d;
  logic [2:0]    old_age_q, old_age_d;
  slot_t         tbl_q [NSLOT];
  slot_t         tbl_d [NSLOT];
  logic [15:0]   rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;
  slot_t         cur;
  logic [VW-1:0] tgt;
  logic          on_ok;

  assign cur = tbl_q[ADDR_W'(int'(ch_q) * VOICES + int'(idx_q))];
  assign on_ok = hit_q || free_q || (STEAL_EN != 0 && old_q);
  assign tgt = hit_q ? hit_i_q : (free_q ? free_i_q : old_i_q);

  always_comb begin
    st_d = st_q;
    cmd_d = cmd_q;
    ch_d = ch_q;
    key_d = key_q;
    val_d = val_q;
    idx_d = idx_q;
    hit_d = hit_q;
    free_d = free_q;
    old_d = old_q;
    hit_i_d = hit_i_q;
    free_i_d = free_i_q;
    old_i_d = old_i_q;
    old_age_d = old_age_q;
    tbl_d = tbl_q;
    drop_d = p_drop;
    unique case (st_q)
      E_IDLE: begin
        if (p_vld) begin
          cmd_d = p_cmd;
          ch_d = p_ch;
          key_d = p_key;
          val_d = p_val;
          idx_d = '0;
          hit_d = 1'b0;
          free_d = 1'b0;
          old_d = 1'b0;
          old_age_d = '0;
          st_d = E_SCAN;
        end
      end
      E_SCAN: begin
        if (cur.active && cur.note == key_q && !hit_q) begin
          hit_d = 1'b1;
          hit_i_d = idx_q;
        end
        if (!cur.active && !free_q) begin
          free_d = 1'b1;
          free_i_d = idx_q;
        end
        // Strict compare keeps the lowest index on age ties.
        if (cur.active && (!old_q || cur.age > old_age_q)) begin
          old_d = 1'b1;
          old_i_d = idx_q;
          old_age_d = cur.age;
        end
        if (idx_q == VW'(VOICES - 1)) st_d = E_COMMIT;
        else idx_d = idx_q + VW'(1);
      end
      E_COMMIT: begin
        st_d = E_IDLE;
        if (cmd_q == CMD_ON && !on_ok) drop_d = 1'b1;
        for (int i = 0; i < VOICES; i++) begin
          unique case (cmd_q)
            CMD_ON: begin
              if (on_ok && VW'(i) == tgt) begin
                tbl_d[int'(ch_q)*VOICES+i] =
                  '{1'b1, key_q, val_q, 3'd0};
              end else if (on_ok
                           && tbl_q[int'(ch_q)*VOICES+i].active
                           && tbl_q[int'(ch_q)*VOICES+i].age
                              < AGE_MAX) begin
                tbl_d[int'(ch_q)*VOICES+i].age =
                  tbl_q[int'(ch_q)*VOICES+i].age + 3'd1;
              end
            end
            CMD_OFF: begin
              if (tbl_q[int'(ch_q)*VOICES+i].active
                  && tbl_q[int'(ch_q)*VOICES+i].note == key_q) begin
                tbl_d[int'(ch_q)*VOICES+i].active = 1'b0;
                tbl_d[int'(ch_q)*VOICES+i].age = 3'd0;
              end
            end
            CMD_ALLOFF: begin
              tbl_d[int'(ch_q)*VOICES+i].active = 1'b0;
              tbl_d[int'(ch_q)*VOICES+i].age = 3'd0;
            end
            default: ;
          endcase
        end
      end
      default: st_d = E_IDLE;
    endcase
    if (p_vld && st_q != E_IDLE) drop_d = 1'b1;
    busy_d = (st_d != E_IDLE);
    rd_d = '0;
    if (int'(i_rdaddr) < NSLOT) rd_d = rd_word(tbl_q[i_rdaddr]);
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      st_q <= E_IDLE;
      cmd_q <= CMD_NONE;
      ch_q <= '0;
      key_q <= '0;
      val_q <= '0;
      idx_q <= '0;
      hit_q <= 1'b0;
      free_q <= 1'b0;
      old_q <= 1'b0;
      hit_i_q <= '0;
      free_i_q <= '0;
      old_i_q <= '0;
      old_age_q <= '0;
      tbl_q <= '{default: '0};
      rd_q <= '0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cmd_q <= cmd_d;
      ch_q <= ch_d;
      key_q <= key_d;
      val_q <= val_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      free_q <= free_d;
      old_q <= old_d;
      hit_i_q <= hit_i_d;
      free_i_q <= free_i_d;
      old_i_q <= old_i_d;
      old_age_q <= old_age_d;
      tbl_q <= tbl_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
    end
  end

  assign o_rddata = rd_q;
  assign o_busy = busy_q;
  assign o_drop = drop_q;

endmodule
